// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// The divider top and its channel sub-module both import this package.
package clk_div_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int DIV_MIN       = 1;

  // High-phase length of a period of length d (rounds toward the high side).
  function automatic int unsigned high_len(input int unsigned d);
    return d - d / 2;
  endfunction

  function automatic int cfg_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active ratio, shadow ratio, pending flag and
// registered outputs. A shadowed ratio takes effect only at a period boundary.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_clk_div,
  output logic             o_stb,
  output logic             o_pend
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pend;
  logic             r_run;
  logic             r_clk_div;
  logic             r_stb;

  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_div_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [CNT_W-1:0] w_high;

  // Every restart point (wrap, sync, idle or just-enabled) is a period
  // boundary, so the shadow is copied there; when nothing is pending the
  // shadow already equals the active ratio.
  always_comb begin
    w_wrap  = r_run && (r_cnt == r_div - CNT_W'(1));
    w_apply = i_sync || !r_run || !i_en || w_wrap;
    w_div_n = w_apply ? r_shadow : r_div;
    w_cnt_n = w_apply ? '0 : r_cnt + CNT_W'(1);
    w_high  = CNT_W'(high_len(32'(w_div_n)));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_div     <= CNT_W'(DEFAULT_DIV);
      r_shadow  <= CNT_W'(DEFAULT_DIV);
      r_pend    <= 1'b0;
      r_run     <= 1'b0;
      r_clk_div <= 1'b0;
      r_stb     <= 1'b0;
    end else begin
      r_run     <= i_en;
      r_cnt     <= w_cnt_n;
      r_div     <= w_div_n;
      r_clk_div <= i_en && (w_cnt_n < w_high);
      r_stb     <= i_en && (w_cnt_n == w_div_n - CNT_W'(1));
      if (i_load) begin
        r_shadow <= i_div;
        r_pend   <= 1'b1;
      end else if (w_apply) begin
        r_pend   <= 1'b0;
      end
    end
  end

  assign o_clk_div = r_clk_div;
  assign o_stb     = r_stb;
  assign o_pend    = r_pend;

endmodule

// File: rtl/clock_divider_prog.sv
// Programmable multi-channel divided-clock / clock-enable generator.
// Decodes ratio-update requests and fans them out to the divider channels.
module clock_divider_prog
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = 2,
  parameter int IDX_W       = cfg_idx_w(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_sync,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [IDX_W-1:0]  i_cfg_ch,
  input  logic [CNT_W-1:0]  i_cfg_div,
  output logic              o_cfg_err,
  output logic [NUM_CH-1:0] o_clk_div,
  output logic [NUM_CH-1:0] o_stb,
  output logic [NUM_CH-1:0] o_pend
);

  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_pend;
  logic              w_ch_ok;
  logic              w_div_ok;
  logic              w_pend_sel;
  logic              w_ready;
  logic              w_fire;
  logic              w_bad;
  logic              r_err;

  // Config handshake: a request transfers on a rising edge where
  // i_cfg_valid && o_cfg_ready. Ready drops only while the addressed channel
  // still holds an unapplied ratio; out-of-range channels always accept so
  // the request can be rejected and the error reported.
  always_comb begin
    w_ch_ok    = 32'(i_cfg_ch) < 32'(NUM_CH);
    w_div_ok   = i_cfg_div >= CNT_W'(DIV_MIN);
    w_pend_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_cfg_ch == IDX_W'(i)) w_pend_sel = w_pend[i];
    end
    w_ready = !w_ch_ok || !w_pend_sel;
    w_fire  = i_cfg_valid && w_ready;
    w_bad   = w_fire && (!w_ch_ok || !w_div_ok);
    for (int i = 0; i < NUM_CH; i++) begin
      w_load[i] = w_fire && w_ch_ok && w_div_ok && (i_cfg_ch == IDX_W'(i));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_err <= 1'b0;
    else       r_err <= w_bad;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en[g]),
      .i_sync    (i_sync),
      .i_load    (w_load[g]),
      .i_div     (i_cfg_div),
      .o_clk_div (o_clk_div[g]),
      .o_stb     (o_stb[g]),
      .o_pend    (w_pend[g])
    );
  end

  assign o_cfg_ready = w_ready;
  assign o_cfg_err   = r_err;
  assign o_pend      = w_pend;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: reset, ratio updates, handshake
// back-pressure, rejected requests, global sync and mid-run reset.
module tb_clock_divider_prog;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = 3;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [NUM_CH-1:0] i_en;
  logic              i_sync;
  logic              i_cfg_valid;
  logic              o_cfg_ready;
  logic [IDX_W-1:0]  i_cfg_ch;
  logic [CNT_W-1:0]  i_cfg_div;
  logic              o_cfg_err;
  logic [NUM_CH-1:0] o_clk_div;
  logic [NUM_CH-1:0] o_stb;
  logic [NUM_CH-1:0] o_pend;

  int n_cmp = 0;
  int n_bad = 0;

  clock_divider_prog #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_sync      (i_sync),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_ch    (i_cfg_ch),
    .i_cfg_div   (i_cfg_div),
    .o_cfg_err   (o_cfg_err),
    .o_clk_div   (o_clk_div),
    .o_stb       (o_stb),
    .o_pend      (o_pend)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic cfg(input logic v, input logic [IDX_W-1:0] ch, input logic [CNT_W-1:0] dv);
    i_cfg_valid = v;
    i_cfg_ch    = ch;
    i_cfg_div   = dv;
  endtask

  // ch1 expected from the cycle D=5 takes effect, then D=3 after the next wrap
  logic       exp_c1_clk[11] = '{1,1,1,0,0, 1,1,0, 1,1,0};
  logic       exp_c1_stb[11] = '{0,0,0,0,1, 0,0,1, 0,0,1};
  logic       exp_c1_pnd[11] = '{0,1,1,1,1, 0,0,0, 0,0,0};
  // cycles 1..7 after sync, ch0 D=3, ch1 D=4, ch2 D=7
  logic [4:0] exp_s_clk[7] = '{5'b00111, 5'b00111, 5'b00100, 5'b00101,
                               5'b00011, 5'b00010, 5'b00001};
  logic [4:0] exp_s_stb[7] = '{5'b00000, 5'b00000, 5'b00001, 5'b00010,
                               5'b00000, 5'b00001, 5'b00100};

  initial begin
    i_rst = 1'b1; i_en = '0; i_sync = 1'b0;
    cfg(1'b0, '0, '0);
    tick(); tick();
    check_eq("rst_clk",   32'(o_clk_div), 0);
    check_eq("rst_stb",   32'(o_stb), 0);
    check_eq("rst_pend",  32'(o_pend), 0);
    check_eq("rst_err",   32'(o_cfg_err), 0);
    check_eq("rst_ready", 32'(o_cfg_ready), 1);

    // ch0 alone at the default ratio of 2
    i_rst = 1'b0; i_en = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("d2_clk", 32'(o_clk_div), (i % 2 == 0) ? 32'h1 : 32'h0);
      check_eq("d2_stb", 32'(o_stb),     (i % 2 == 1) ? 32'h1 : 32'h0);
    end

    // ch1 gets ratio 5 mid-period, then a second request waits for the wrap
    i_en = 5'b00011;
    tick();
    check_eq("en_rise_clk", 32'(o_clk_div), 32'b00011);
    check_eq("en_rise_stb", 32'(o_stb), 0);
    cfg(1'b1, 3'd1, 16'd5);
    #1 check_eq("ready_idle", 32'(o_cfg_ready), 1);
    tick();
    check_eq("old_period_clk", 32'(o_clk_div[1]), 0);
    check_eq("old_period_stb", 32'(o_stb[1]), 1);
    check_eq("pend_set", 32'(o_pend), 32'b00010);
    cfg(1'b1, 3'd1, 16'd3);
    #1 check_eq("ready_busy", 32'(o_cfg_ready), 0);
    for (int k = 0; k < 11; k++) begin
      tick();
      if (k == 0) check_eq("ready_after_wrap", 32'(o_cfg_ready), 1);
      if (k == 1) begin
        check_eq("no_err_good_req", 32'(o_cfg_err), 0);
        cfg(1'b0, '0, '0);
      end
      check_eq("ratio_clk1", 32'(o_clk_div[1]), 32'(exp_c1_clk[k]));
      check_eq("ratio_stb1", 32'(o_stb[1]),     32'(exp_c1_stb[k]));
      check_eq("ratio_pend", 32'(o_pend),       {31'b0, exp_c1_pnd[k]} << 1);
    end

    // rejected requests: zero ratio, out-of-range channel
    cfg(1'b1, 3'd2, 16'd0);
    #1 check_eq("ready_div0", 32'(o_cfg_ready), 1);
    tick();
    check_eq("err_div0", 32'(o_cfg_err), 1);
    check_eq("err_div0_pend", 32'(o_pend), 0);
    cfg(1'b0, '0, '0);
    tick();
    check_eq("err_div0_end", 32'(o_cfg_err), 0);
    cfg(1'b1, 3'd7, 16'd4);
    #1 check_eq("ready_badch", 32'(o_cfg_ready), 1);
    tick();
    check_eq("err_badch", 32'(o_cfg_err), 1);
    check_eq("err_badch_pend", 32'(o_pend), 0);
    cfg(1'b0, '0, '0);
    tick();
    check_eq("err_badch_end", 32'(o_cfg_err), 0);
    i_en = 5'b00100;
    tick();
    check_eq("ch2_d2_clk0", 32'(o_clk_div), 32'b00100);
    check_eq("ch2_d2_stb0", 32'(o_stb), 0);
    tick();
    check_eq("ch2_d2_clk1", 32'(o_clk_div), 0);
    check_eq("ch2_d2_stb1", 32'(o_stb), 32'b00100);

    // program 3/4/7 while idle, start at staggered phases, then sync
    i_en = '0;
    tick();
    cfg(1'b1, 3'd0, 16'd3); tick();
    cfg(1'b1, 3'd1, 16'd4); tick();
    cfg(1'b1, 3'd2, 16'd7); tick();
    cfg(1'b0, '0, '0);      tick();
    check_eq("idle_apply_pend", 32'(o_pend), 0);
    i_en = 5'b00001; tick();
    i_en = 5'b00011; tick(); tick();
    i_en = 5'b00111; tick(); tick(); tick();
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      check_eq("sync_clk", 32'(o_clk_div), 32'(exp_s_clk[c]));
      check_eq("sync_stb", 32'(o_stb),     32'(exp_s_stb[c]));
    end

    // reset mid-count with ratio 5 pending on ch3
    i_en = 5'b01000;
    tick();
    check_eq("ch3_start", 32'(o_clk_div), 32'b01000);
    cfg(1'b1, 3'd3, 16'd5);
    tick();
    check_eq("ch3_pend", 32'(o_pend), 32'b01000);
    check_eq("ch3_stb", 32'(o_stb), 32'b01000);
    cfg(1'b0, '0, '0);
    i_rst = 1'b1;
    #1;
    check_eq("arst_clk",  32'(o_clk_div), 0);
    check_eq("arst_stb",  32'(o_stb), 0);
    check_eq("arst_pend", 32'(o_pend), 0);
    check_eq("arst_err",  32'(o_cfg_err), 0);
    tick();
    i_rst = 1'b0;
    tick();
    check_eq("post_rst_clk0", 32'(o_clk_div), 32'b01000);
    check_eq("post_rst_pend", 32'(o_pend), 0);
    tick();
    check_eq("post_rst_clk1", 32'(o_clk_div), 0);
    check_eq("post_rst_stb1", 32'(o_stb), 32'b01000);
    tick();
    check_eq("post_rst_clk2", 32'(o_clk_div), 32'b01000);
    check_eq("post_rst_stb2", 32'(o_stb), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
